// File: rtl/wb_commit_stage.sv
// Write-back / commit stage: holds one instruction from MEM, waits for load data
// when needed, then commits regfile/CSR/exception side effects for one cycle.
module wb_commit_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RF_AW  = 5,
  parameter int unsigned CSR_NW = 14,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_to_wb_valid,
  output logic              wb_allowin,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              in_rf_we,
  input  logic [RF_AW-1:0]  in_rf_waddr,
  input  logic [DATA_W-1:0] in_rf_wdata,
  input  logic              in_ld_wait,
  input  logic              in_csr_re,
  input  logic              in_csr_we,
  input  logic [CSR_NW-1:0] in_csr_num,
  input  logic [DATA_W-1:0] in_csr_wmask,
  input  logic [DATA_W-1:0] in_csr_wvalue,
  input  logic              in_ertn,
  input  logic              in_ex,
  input  logic [5:0]        in_ecode,
  input  logic [8:0]        in_esubcode,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic [DATA_W-1:0] csr_rvalue,
  output logic              wb_rf_we,
  output logic [RF_AW-1:0]  wb_rf_waddr,
  output logic [DATA_W-1:0] wb_rf_wdata,
  output logic              wb_ld_busy,
  output logic              csr_re,
  output logic              csr_we,
  output logic [CSR_NW-1:0] csr_num,
  output logic [DATA_W-1:0] csr_wmask,
  output logic [DATA_W-1:0] csr_wvalue,
  output logic              wb_ex,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [DATA_W-1:0] wb_ex_pc,
  output logic              ertn_flush,
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [RF_AW-1:0]  debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic wb_valid;
  logic wb_ready_go;
  logic accept;
  logic commit;

  logic [DATA_W-1:0] pc_r;
  logic              rf_we_r;
  logic [RF_AW-1:0]  rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic              csr_re_r;
  logic              csr_we_r;
  logic [CSR_NW-1:0] csr_num_r;
  logic [DATA_W-1:0] csr_wmask_r;
  logic [DATA_W-1:0] csr_wvalue_r;
  logic              ertn_r;
  logic              ex_r;
  logic [5:0]        ecode_r;
  logic [8:0]        esubcode_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] result;

  // Handshake and next-state; data_ok only matters while a load is pending.
  always_comb begin
    wb_valid    = (state != S_EMPTY);
    wb_ready_go = 1'b0;
    case (state)
      S_HOLD:  wb_ready_go = 1'b1;
      S_WAIT:  wb_ready_go = data_ok;
      default: wb_ready_go = 1'b0;
    endcase
    wb_allowin = ~wb_valid | wb_ready_go;
    accept     = mem_to_wb_valid & wb_allowin;
    commit     = wb_valid & wb_ready_go;

    state_nxt = state;
    if (accept) begin
      state_nxt = (in_ld_wait & ~in_ex) ? S_WAIT : S_HOLD;
    end else if (wb_allowin) begin
      state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_r         <= '0;
      rf_we_r      <= 1'b0;
      rf_waddr_r   <= '0;
      rf_wdata_r   <= '0;
      csr_re_r     <= 1'b0;
      csr_we_r     <= 1'b0;
      csr_num_r    <= '0;
      csr_wmask_r  <= '0;
      csr_wvalue_r <= '0;
      ertn_r       <= 1'b0;
      ex_r         <= 1'b0;
      ecode_r      <= '0;
      esubcode_r   <= '0;
    end else if (accept) begin
      pc_r         <= in_pc;
      rf_we_r      <= in_rf_we;
      rf_waddr_r   <= in_rf_waddr;
      rf_wdata_r   <= in_rf_wdata;
      csr_re_r     <= in_csr_re;
      csr_we_r     <= in_csr_we;
      csr_num_r    <= in_csr_num;
      csr_wmask_r  <= in_csr_wmask;
      csr_wvalue_r <= in_csr_wvalue;
      ertn_r       <= in_ertn;
      ex_r         <= in_ex;
      ecode_r      <= in_ecode;
      esubcode_r   <= in_esubcode;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r <= '0;
    end else if (commit & ~ex_r) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  always_comb begin
    // Only the WAIT state selects load data, so a stray data_ok elsewhere is inert.
    if (state == S_WAIT) begin
      result = data_rdata;
    end else if (csr_re_r) begin
      result = csr_rvalue;
    end else begin
      result = rf_wdata_r;
    end

    wb_rf_we          = commit & rf_we_r & ~ex_r;
    wb_rf_waddr       = rf_waddr_r;
    wb_rf_wdata       = result;
    wb_ld_busy        = (state == S_WAIT) & rf_we_r & ~data_ok;

    csr_re            = csr_re_r;
    csr_we            = commit & csr_we_r & ~ex_r;
    csr_num           = csr_num_r;
    csr_wmask         = csr_wmask_r;
    csr_wvalue        = csr_wvalue_r;

    wb_ex             = commit & ex_r;
    wb_ecode          = ecode_r;
    wb_esubcode       = esubcode_r;
    wb_ex_pc          = pc_r;
    ertn_flush        = commit & ertn_r & ~ex_r;

    debug_wb_pc       = pc_r;
    debug_wb_rf_we    = {4{wb_rf_we}};
    debug_wb_rf_wnum  = rf_waddr_r;
    debug_wb_rf_wdata = result;

    retire_cnt        = cnt_r;
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed sequences, a vector table, and a
// register-write scoreboard checked on every wb_rf_we pulse.
module tb_wb_commit_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NW = 14;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          mem_to_wb_valid;
  logic          wb_allowin;
  logic [DW-1:0] in_pc;
  logic          in_rf_we;
  logic [AW-1:0] in_rf_waddr;
  logic [DW-1:0] in_rf_wdata;
  logic          in_ld_wait;
  logic          in_csr_re;
  logic          in_csr_we;
  logic [NW-1:0] in_csr_num;
  logic [DW-1:0] in_csr_wmask;
  logic [DW-1:0] in_csr_wvalue;
  logic          in_ertn;
  logic          in_ex;
  logic [5:0]    in_ecode;
  logic [8:0]    in_esubcode;
  logic          data_ok;
  logic [DW-1:0] data_rdata;
  logic [DW-1:0] csr_rvalue;
  logic          wb_rf_we;
  logic [AW-1:0] wb_rf_waddr;
  logic [DW-1:0] wb_rf_wdata;
  logic          wb_ld_busy;
  logic          csr_re;
  logic          csr_we;
  logic [NW-1:0] csr_num;
  logic [DW-1:0] csr_wmask;
  logic [DW-1:0] csr_wvalue;
  logic          wb_ex;
  logic [5:0]    wb_ecode;
  logic [8:0]    wb_esubcode;
  logic [DW-1:0] wb_ex_pc;
  logic          ertn_flush;
  logic [DW-1:0] debug_wb_pc;
  logic [3:0]    debug_wb_rf_we;
  logic [AW-1:0] debug_wb_rf_wnum;
  logic [DW-1:0] debug_wb_rf_wdata;
  logic [CW-1:0] retire_cnt;

  wb_commit_stage #(
    .DATA_W(DW),
    .RF_AW (AW),
    .CSR_NW(NW),
    .CNT_W (CW)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .wb_allowin       (wb_allowin),
    .in_pc            (in_pc),
    .in_rf_we         (in_rf_we),
    .in_rf_waddr      (in_rf_waddr),
    .in_rf_wdata      (in_rf_wdata),
    .in_ld_wait       (in_ld_wait),
    .in_csr_re        (in_csr_re),
    .in_csr_we        (in_csr_we),
    .in_csr_num       (in_csr_num),
    .in_csr_wmask     (in_csr_wmask),
    .in_csr_wvalue    (in_csr_wvalue),
    .in_ertn          (in_ertn),
    .in_ex            (in_ex),
    .in_ecode         (in_ecode),
    .in_esubcode      (in_esubcode),
    .data_ok          (data_ok),
    .data_rdata       (data_rdata),
    .csr_rvalue       (csr_rvalue),
    .wb_rf_we         (wb_rf_we),
    .wb_rf_waddr      (wb_rf_waddr),
    .wb_rf_wdata      (wb_rf_wdata),
    .wb_ld_busy       (wb_ld_busy),
    .csr_re           (csr_re),
    .csr_we           (csr_we),
    .csr_num          (csr_num),
    .csr_wmask        (csr_wmask),
    .csr_wvalue       (csr_wvalue),
    .wb_ex            (wb_ex),
    .wb_ecode         (wb_ecode),
    .wb_esubcode      (wb_esubcode),
    .wb_ex_pc         (wb_ex_pc),
    .ertn_flush       (ertn_flush),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_we   (debug_wb_rf_we),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retire_cnt       (retire_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_cnt;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } wr_t;
  wr_t sb_q[$];

  typedef struct {
    string         name;
    logic [DW-1:0] pc;
    logic          rf_we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          csr_re;
    logic [DW-1:0] rval;
    logic          csr_we;
    logic [NW-1:0] num;
    logic [DW-1:0] mask;
    logic [DW-1:0] wval;
    logic          ex;
    logic          ertn;
    logic [5:0]    ecode;
    logic [8:0]    esub;
    logic          e_rf_we;
    logic [DW-1:0] e_wdata;
    logic          e_ex;
    logic          e_ertn;
    logic          e_csr_we;
    logic          e_inc;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives happen 1 time unit after the rising edge, samples on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    mem_to_wb_valid = 1'b0;
    in_pc = '0; in_rf_we = 1'b0; in_rf_waddr = '0; in_rf_wdata = '0;
    in_ld_wait = 1'b0; in_csr_re = 1'b0; in_csr_we = 1'b0; in_csr_num = '0;
    in_csr_wmask = '0; in_csr_wvalue = '0; in_ertn = 1'b0; in_ex = 1'b0;
    in_ecode = '0; in_esubcode = '0; data_ok = 1'b0; data_rdata = '0; csr_rvalue = '0;
  endtask

  task automatic drive_alu(input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
    clear_inputs();
    mem_to_wb_valid = 1'b1;
    in_pc       = 32'h1C00_0000 + {wdata[27:0], 2'b00};
    in_rf_we    = 1'b1;
    in_rf_waddr = waddr;
    in_rf_wdata = wdata;
  endtask

  task automatic drive_load(input logic [AW-1:0] waddr, input logic [DW-1:0] junk);
    clear_inputs();
    mem_to_wb_valid = 1'b1;
    in_pc       = 32'h1C00_2000;
    in_rf_we    = 1'b1;
    in_rf_waddr = waddr;
    in_rf_wdata = junk;
    in_ld_wait  = 1'b1;
  endtask

  task automatic push(input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
    wr_t e;
    e.waddr = waddr;
    e.wdata = wdata;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    next_cycle();
    resetn = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    resetn  = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_allowin"}, 64'(wb_allowin), 64'd1);
    check({tag, "_outs_zero"}, 64'(|{wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_ld_busy, csr_re, csr_we,
                                     csr_num, csr_wmask, csr_wvalue, wb_ex, wb_ecode, wb_esubcode,
                                     wb_ex_pc, ertn_flush, debug_wb_pc, debug_wb_rf_we,
                                     debug_wb_rf_wnum, debug_wb_rf_wdata}), 64'd0);
    check({tag, "_retire_cnt"}, 64'(retire_cnt), 64'd0);
  endtask

  // Scoreboard: every regfile write pulse must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (wb_rf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got write r%0d=0x%0h, required no write", wb_rf_waddr, wb_rf_wdata);
      end else begin
        e = sb_q.pop_front();
        check("sb_waddr", 64'(wb_rf_waddr), 64'(e.waddr));
        check("sb_wdata", 64'(wb_rf_wdata), 64'(e.wdata));
        check("sb_dbg_wnum", 64'(debug_wb_rf_wnum), 64'(e.waddr));
        check("sb_dbg_wdata", 64'(debug_wb_rf_wdata), 64'(e.wdata));
        check("sb_dbg_we", 64'(debug_wb_rf_we), 64'hF);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    clear_inputs();
    exp_cnt = '0;

    vt[0] = '{"alu",    32'h1C00_0000, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 32'h0,    1'b0, 14'h0,   32'h0,         32'h0,    1'b0, 1'b0, 6'h00, 9'h000,
              1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{"ex",     32'h1C00_0100, 1'b1, 5'd3, 32'h77,        1'b0, 32'h0,    1'b0, 14'h0,   32'h0,         32'h0,    1'b1, 1'b1, 6'h0B, 9'h000,
              1'b0, 32'h77,        1'b1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{"csr_rd", 32'h1C00_0104, 1'b1, 5'd8, 32'h999,       1'b1, 32'h5A5A, 1'b0, 14'h0,   32'h0,         32'h0,    1'b0, 1'b0, 6'h00, 9'h000,
              1'b1, 32'h5A5A,      1'b0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{"csr_wr", 32'h1C00_0108, 1'b1, 5'd9, 32'h0,         1'b1, 32'hCAFE, 1'b1, 14'h010, 32'hFF,        32'h1234, 1'b0, 1'b0, 6'h00, 9'h000,
              1'b1, 32'hCAFE,      1'b0, 1'b0, 1'b1, 1'b1};
    vt[4] = '{"ertn",   32'h1C00_010C, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,    1'b0, 14'h0,   32'h0,         32'h0,    1'b0, 1'b1, 6'h00, 9'h000,
              1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1};
    vt[5] = '{"ex_csr", 32'h1C00_0110, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,    1'b1, 14'h003, 32'hFFFF_FFFF, 32'h5,    1'b1, 1'b0, 6'h08, 9'h001,
              1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{"nop",    32'h1C00_0114, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,    1'b0, 14'h0,   32'h0,         32'h0,    1'b0, 1'b0, 6'h00, 9'h000,
              1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1};

    do_reset();
    sample();
    check_reset("reset");

    // Three back-to-back ALU results.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive_alu(AW'(i + 1), 32'(32'h11 * (i + 1)));
      push(AW'(i + 1), 32'(32'h11 * (i + 1)));
      sample();
      check("alu_allowin", 64'(wb_allowin), 64'd1);
      check("alu_we", 64'(wb_rf_we), 64'(i > 0));
    end
    next_cycle();
    clear_inputs();
    sample();
    check("alu_we_last", 64'(wb_rf_we), 64'd1);
    exp_cnt = exp_cnt + CW'(3);
    next_cycle();
    sample();
    check("alu_we_idle", 64'(wb_rf_we), 64'd0);
    check("alu_retire_cnt", 64'(retire_cnt), 64'(exp_cnt));

    // Load with a 3-cycle stall, a younger ALU instruction waiting behind it.
    next_cycle();
    drive_load(5'd4, 32'h0);
    push(5'd4, 32'hDEAD_BEEF);
    push(5'd5, 32'h55);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drive_alu(5'd5, 32'h55);
      sample();
      check("ld_stall_allowin", 64'(wb_allowin), 64'd0);
      check("ld_stall_busy", 64'(wb_ld_busy), 64'd1);
      check("ld_stall_we", 64'(wb_rf_we), 64'd0);
    end
    next_cycle();
    drive_alu(5'd5, 32'h55);
    data_ok    = 1'b1;
    data_rdata = 32'hDEAD_BEEF;
    sample();
    check("ld_commit_we", 64'(wb_rf_we), 64'd1);
    check("ld_commit_busy", 64'(wb_ld_busy), 64'd0);
    check("ld_commit_allowin", 64'(wb_allowin), 64'd1);
    next_cycle();
    clear_inputs();
    sample();
    check("ld_next_we", 64'(wb_rf_we), 64'd1);
    exp_cnt = exp_cnt + CW'(2);
    next_cycle();
    sample();
    check("ld_retire_cnt", 64'(retire_cnt), 64'(exp_cnt));

    // Load whose data returns in the first WB cycle, then a stray data_ok.
    next_cycle();
    drive_load(5'd6, 32'h1234);
    push(5'd6, 32'h600D_F00D);
    next_cycle();
    clear_inputs();
    data_ok    = 1'b1;
    data_rdata = 32'h600D_F00D;
    sample();
    check("fast_ld_we", 64'(wb_rf_we), 64'd1);
    check("fast_ld_allowin", 64'(wb_allowin), 64'd1);
    check("fast_ld_busy", 64'(wb_ld_busy), 64'd0);
    exp_cnt = exp_cnt + CW'(1);
    next_cycle();
    clear_inputs();
    sample();
    check("fast_ld_after_we", 64'(wb_rf_we), 64'd0);
    check("fast_ld_after_wdata", 64'(wb_rf_wdata), 64'h1234);
    next_cycle();
    data_ok    = 1'b1;
    data_rdata = 32'hBAD0_BAD0;
    sample();
    check("stray_ok_we", 64'(wb_rf_we), 64'd0);
    check("stray_ok_busy", 64'(wb_ld_busy), 64'd0);
    check("stray_ok_allowin", 64'(wb_allowin), 64'd1);
    check("stray_ok_wdata", 64'(wb_rf_wdata), 64'h1234);
    next_cycle();
    clear_inputs();
    sample();
    check("stray_ok_retire_cnt", 64'(retire_cnt), 64'(exp_cnt));

    // Vector table: one instruction each, commit cycle then the cycle after.
    for (int v = 0; v < 7; v++) begin
      next_cycle();
      clear_inputs();
      mem_to_wb_valid = 1'b1;
      in_pc = vt[v].pc; in_rf_we = vt[v].rf_we; in_rf_waddr = vt[v].waddr; in_rf_wdata = vt[v].wdata;
      in_csr_re = vt[v].csr_re; in_csr_we = vt[v].csr_we; in_csr_num = vt[v].num;
      in_csr_wmask = vt[v].mask; in_csr_wvalue = vt[v].wval; in_ex = vt[v].ex; in_ertn = vt[v].ertn;
      in_ecode = vt[v].ecode; in_esubcode = vt[v].esub;
      csr_rvalue = vt[v].rval;
      if (vt[v].e_rf_we) push(vt[v].waddr, vt[v].e_wdata);
      next_cycle();
      mem_to_wb_valid = 1'b0;
      sample();
      check({vt[v].name, "_rf_we"}, 64'(wb_rf_we), 64'(vt[v].e_rf_we));
      check({vt[v].name, "_wdata"}, 64'(wb_rf_wdata), 64'(vt[v].e_wdata));
      check({vt[v].name, "_ex"}, 64'(wb_ex), 64'(vt[v].e_ex));
      check({vt[v].name, "_ecode"}, 64'(wb_ecode), 64'(vt[v].ecode));
      check({vt[v].name, "_esub"}, 64'(wb_esubcode), 64'(vt[v].esub));
      check({vt[v].name, "_ex_pc"}, 64'(wb_ex_pc), 64'(vt[v].pc));
      check({vt[v].name, "_dbg_pc"}, 64'(debug_wb_pc), 64'(vt[v].pc));
      check({vt[v].name, "_ertn_flush"}, 64'(ertn_flush), 64'(vt[v].e_ertn));
      check({vt[v].name, "_csr_we"}, 64'(csr_we), 64'(vt[v].e_csr_we));
      check({vt[v].name, "_csr_re"}, 64'(csr_re), 64'(vt[v].csr_re));
      check({vt[v].name, "_csr_num"}, 64'(csr_num), 64'(vt[v].num));
      check({vt[v].name, "_csr_wmask"}, 64'(csr_wmask), 64'(vt[v].mask));
      check({vt[v].name, "_csr_wvalue"}, 64'(csr_wvalue), 64'(vt[v].wval));
      exp_cnt = exp_cnt + CW'(vt[v].e_inc);
      next_cycle();
      sample();
      check({vt[v].name, "_pulses_end"}, 64'({wb_rf_we, wb_ex, ertn_flush, csr_we}), 64'd0);
      check({vt[v].name, "_retire_cnt"}, 64'(retire_cnt), 64'(exp_cnt));
    end

    // Counter wrap: 17 commits on a 4-bit counter from zero.
    do_reset();
    sample();
    check_reset("reset2");
    for (int i = 0; i < 17; i++) begin
      next_cycle();
      drive_alu(AW'(i + 10), 32'(i + 100));
      push(AW'(i + 10), 32'(i + 100));
    end
    next_cycle();
    clear_inputs();
    exp_cnt = exp_cnt + CW'(17);
    next_cycle();
    sample();
    check("wrap_retire_cnt", 64'(retire_cnt), 64'd1);
    check("wrap_retire_model", 64'(retire_cnt), 64'(exp_cnt));

    // Reset while a load is pending: load discarded, late data_ok ignored.
    next_cycle();
    drive_load(5'd9, 32'h0);
    next_cycle();
    clear_inputs();
    sample();
    check("rst_wait_busy", 64'(wb_ld_busy), 64'd1);
    check("rst_wait_allowin", 64'(wb_allowin), 64'd0);
    next_cycle();
    resetn = 1'b0;
    next_cycle();
    resetn  = 1'b1;
    exp_cnt = '0;
    sample();
    check_reset("rst_wait");
    next_cycle();
    data_ok    = 1'b1;
    data_rdata = 32'h0BAD_0BAD;
    sample();
    check_reset("rst_wait_late_ok");
    next_cycle();
    clear_inputs();
    sample();

    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
